// File: rtl/seg_mux_driver_if.sv
// Display driver bus: hex/blank/blink inputs from the datapath side,
// segment/anode pins and frame marker back out.
interface seg_mux_driver_if #(
  parameter int N_DIGITS = 2
);
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   blank;
  logic [N_DIGITS-1:0]   blink;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  modport master (
    output digits, blank, blink,
    input  seg, an, frame_tick
  );

  modport slave (
    input  digits, blank, blink,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg_mux_driver.sv
// Time-multiplexed common-anode hex display driver.
// One digit per refresh slot, all anodes off for the first DEAD_CYCLES of
// each slot, per-digit blank/blink, and inputs sampled once per frame so a
// frame never mixes old and new values.

// Per-digit hex to active-low seven-segment decoder (bit0=a .. bit6=g).
module seg_decode (
  input  logic [3:0] val,
  output logic [6:0] seg
);
  // Pure lookup; no state.
  always_comb begin
    seg = 7'h7F;
    unique case (val)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module seg_mux_driver #(
  parameter int N_DIGITS    = 2,
  parameter int REFRESH_DIV = 24000,
  parameter int DEAD_CYCLES = 480,
  parameter int BLINK_DIV   = 20_000_000
) (
  input  logic            int_osc,
  input  logic            reset,
  seg_mux_driver_if.slave bus
);

  localparam int IW = (N_DIGITS > 1)  ? $clog2(N_DIGITS)    : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV)   : 1;

  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] DEAD_END   = RW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Reject parameter sets that would leave no lit time or no dead time.
  generate
    if (N_DIGITS < 1 || REFRESH_DIV < 3 || DEAD_CYCLES < 1 ||
        DEAD_CYCLES > REFRESH_DIV - 2 || BLINK_DIV < 1) begin : g_bad_params
      $error("seg_mux_driver: illegal parameter combination");
    end
  endgenerate

  // Counter and shadow state.
  logic [RW-1:0]                ref_cnt, ref_nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic [BW-1:0]                blink_cnt, blink_cnt_nxt;
  logic                         blink_phase, blink_phase_nxt;
  logic [N_DIGITS-1:0][3:0]     sh_dig, sh_dig_nxt;
  logic [N_DIGITS-1:0]          sh_blank, sh_blank_nxt;
  logic [N_DIGITS-1:0]          sh_blink, sh_blink_nxt;

  logic                         ref_wrap, frame_wrap;

  // Registered-output next values.
  logic [6:0]                   seg_nxt;
  logic [N_DIGITS-1:0]          an_nxt;
  logic                         digit_off;

  // Decoded pattern for every shadowed digit; the active one is muxed below.
  logic [N_DIGITS-1:0][6:0]     dec;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_lane
      seg_decode u_dec (
        .val (sh_dig_nxt[gi]),
        .seg (dec[gi])
      );
    end
  endgenerate

  // Refresh slot counter, digit index and frame boundary.
  always_comb begin
    ref_wrap   = (ref_cnt == REF_LAST);
    ref_nxt    = ref_wrap ? '0 : ref_cnt + 1'b1;
    idx_nxt    = idx;
    frame_wrap = 1'b0;
    if (ref_wrap) begin
      if (idx == IDX_LAST) begin
        idx_nxt    = '0;
        frame_wrap = 1'b1;
      end else begin
        idx_nxt    = idx + 1'b1;
      end
    end
  end

  // Free-running blink divider; phase 1 is the off half.
  always_comb begin
    blink_cnt_nxt   = blink_cnt + 1'b1;
    blink_phase_nxt = blink_phase;
    if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end
  end

  // Shadows only follow the inputs on the frame wrap edge.
  always_comb begin
    sh_dig_nxt   = sh_dig;
    sh_blank_nxt = sh_blank;
    sh_blink_nxt = sh_blink;
    if (frame_wrap) begin
      sh_dig_nxt   = bus.digits;
      sh_blank_nxt = bus.blank;
      sh_blink_nxt = bus.blink;
    end
  end

  // Output pattern from next-state values so it lines up with the slot
  // position held in the same cycle.
  always_comb begin
    seg_nxt   = 7'h7F;
    an_nxt    = '1;
    digit_off = sh_blank_nxt[idx_nxt] | (sh_blink_nxt[idx_nxt] & blink_phase_nxt);
    if (ref_nxt >= DEAD_END && !digit_off) begin
      seg_nxt = dec[idx_nxt];
      an_nxt  = ~(N_DIGITS'(1) << idx_nxt);
    end
  end

  // State registers; reset forces the display dark without waiting for a clock.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      ref_cnt        <= '0;
      idx            <= '0;
      blink_cnt      <= '0;
      blink_phase    <= 1'b0;
      sh_dig         <= '0;
      sh_blank       <= '1;
      sh_blink       <= '0;
      bus.seg        <= 7'h7F;
      bus.an         <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      ref_cnt        <= ref_nxt;
      idx            <= idx_nxt;
      blink_cnt      <= blink_cnt_nxt;
      blink_phase    <= blink_phase_nxt;
      sh_dig         <= sh_dig_nxt;
      sh_blank       <= sh_blank_nxt;
      sh_blink       <= sh_blink_nxt;
      bus.seg        <= seg_nxt;
      bus.an         <= an_nxt;
      bus.frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver with small divisors. The reference model tracks
// only the number of edges since reset plus the frame-captured inputs and
// derives slot, digit, blink phase and frame boundaries arithmetically.
module tb_seg_mux_driver;
  localparam int N  = 2;
  localparam int R  = 8;
  localparam int D  = 2;
  localparam int B  = 32;
  localparam int FR = N * R;

  logic int_osc;
  logic reset;

  seg_mux_driver_if #(.N_DIGITS(N)) bus ();

  seg_mux_driver #(
    .N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .BLINK_DIV(B)
  ) u_dut (
    .int_osc (int_osc),
    .reset   (reset),
    .bus     (bus)
  );

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: edge count since reset and captured inputs.
  int             t;
  logic [4*N-1:0] m_dig;
  logic [N-1:0]   m_blank, m_blink;

  always @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      t       <= 0;
      m_dig   <= '0;
      m_blank <= '1;
      m_blink <= '0;
    end else begin
      t <= t + 1;
      if ((t + 1) % FR == 0) begin
        m_dig   <= bus.digits;
        m_blank <= bus.blank;
        m_blink <= bus.blink;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the update edge.
  always @(negedge int_osc) begin
    if (reset) begin
      int         slot, di, ph;
      logic       lit;
      logic [6:0] eseg;
      logic [1:0] ean;
      slot = t % R;
      di   = (t / R) % N;
      ph   = (t / B) % 2;
      lit  = (slot >= D) && !(m_blank[di] || (m_blink[di] && ph == 1));
      eseg = lit ? dec_tab[m_dig[di*4 +: 4]] : 7'h7F;
      ean  = lit ? ~(2'b01 << di) : 2'b11;
      chk("seg", 32'(bus.seg), 32'(eseg));
      chk("an", 32'(bus.an), 32'(ean));
      chk("frame_tick", 32'(bus.frame_tick), 32'((t != 0 && t % FR == 0) ? 1 : 0));
      chk("an_onehot0", 32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge int_osc);
  endtask

  task automatic set_in(input logic [7:0] d, input logic [1:0] bl, input logic [1:0] bk);
    @(negedge int_osc);
    #1;
    bus.digits = d;
    bus.blank  = bl;
    bus.blink  = bk;
  endtask

  initial begin
    bit found;
    reset      = 1'b0;
    bus.digits = 8'h3A;
    bus.blank  = 2'b00;
    bus.blink  = 2'b00;
    #7;
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_an", 32'(bus.an), 32'h3);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge int_osc);
    #2 reset = 1'b1;

    // Dark first frame, then 3A; digits change mid-frame to 81.
    run(19);
    #1 bus.digits = 8'h81;
    run(30);

    // Digit 1 blanked.
    set_in(8'h81, 2'b10, 2'b00);
    run(40);

    // Digit 0 blinking over several blink periods.
    set_in(8'h5C, 2'b00, 2'b01);
    run(140);

    // Random input changes at arbitrary points within frames.
    for (int i = 0; i < 30; i++) begin
      set_in(8'($urandom),
             ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
             ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
      run($urandom_range(1, 40));
    end

    // Reset in the middle of a lit digit-0 slot.
    set_in(8'h7E, 2'b00, 2'b00);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge int_osc);
      if (bus.an == 2'b10) found = 1'b1;
    end
    chk("wait_lit_slot", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(bus.seg), 32'h7F);
    chk("mid_rst_an", 32'(bus.an), 32'h3);
    chk("mid_rst_tick", 32'(bus.frame_tick), 32'h0);
    run(3);
    #2 reset = 1'b1;
    run(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
